// File: rtl/s_coef_bank.sv
// Coefficient bank: NUM_VECTORS polynomial coefficient vectors with random reads and Horner-order bursts.
// Build option S_COEF_BANK_RAW_BYPASS_EN forwards same-cycle write data to a read of the same address.
module s_coef_bank #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_VECTORS = 8,
  parameter int MAX_DEGREE  = 10,
  localparam int VA = (NUM_VECTORS > 2) ? $clog2(NUM_VECTORS) : 1,
  localparam int CA = (MAX_DEGREE > 0) ? $clog2(MAX_DEGREE + 1) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [VA-1:0]        wr_vec,
  input  logic [CA-1:0]        wr_coef,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 clr_en,
  input  logic [VA-1:0]        clr_vec,
  input  logic                 re_en,
  input  logic [VA-1:0]        rd_vec,
  input  logic [CA-1:0]        rd_coef,
  input  logic                 stream_start,
  input  logic [VA-1:0]        stream_vec,
  output logic [WORD_SIZE-1:0] q,
  output logic                 q_en,
  output logic                 stream_busy,
  output logic                 stream_last,
  output logic                 wr_suc,
  output logic                 err,
  output logic [CA-1:0]        deg_out,
  output logic                 state_dbg
);

  // Handshake: every request is a one-cycle strobe with no back-pressure; the
  // verdict (wr_suc or err) and any read data with q_en appear one cycle later.
  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                 state;
  logic [WORD_SIZE-1:0]   mem [NUM_VECTORS][MAX_DEGREE+1];
  logic [NUM_VECTORS-1:0] valid;
  logic [CA-1:0]          deg [NUM_VECTORS];
  logic [VA-1:0]          s_vec;
  logic [CA-1:0]          s_idx;

  logic                   wr_ok;
  logic                   wr_bad;
  logic                   clr_ok;
  logic                   wr_cur_valid;
  logic [CA-1:0]          wr_cur_deg;
  logic [CA-1:0]          new_deg;
  logic                   st_vec_valid;
  logic [CA-1:0]          st_deg;
  logic                   st_ok;
  logic                   st_bad;
  logic                   rd_ok;
  logic                   rd_bad;
  logic                   step;
  logic [VA-1:0]          a_vec;
  logic [CA-1:0]          a_coef;
  logic                   gate;
  logic [WORD_SIZE-1:0]   rd_word;

  function automatic logic vec_in(input logic [VA-1:0] v);
    return 32'(v) < 32'(NUM_VECTORS);
  endfunction

  function automatic logic coef_in(input logic [CA-1:0] c);
    return 32'(c) <= 32'(MAX_DEGREE);
  endfunction

  always_comb begin
    wr_ok        = wr_en && vec_in(wr_vec) && coef_in(wr_coef);
    wr_bad       = wr_en && !wr_ok;
    clr_ok       = clr_en && vec_in(clr_vec);
    wr_cur_valid = 1'b0;
    wr_cur_deg   = '0;
    if (wr_ok) begin
      wr_cur_valid = valid[wr_vec];
      wr_cur_deg   = deg[wr_vec];
    end
    // A write restarts the degree when the vector is (or is being) invalidated.
    if (!wr_cur_valid || (clr_ok && clr_vec == wr_vec)) begin
      new_deg = wr_coef;
    end else if (wr_coef > wr_cur_deg) begin
      new_deg = wr_coef;
    end else begin
      new_deg = wr_cur_deg;
    end

    st_vec_valid = 1'b0;
    st_deg       = '0;
    if (vec_in(stream_vec)) begin
      st_vec_valid = valid[stream_vec];
      st_deg       = deg[stream_vec];
    end
    st_ok  = (state == IDLE) && stream_start && st_vec_valid;
    st_bad = stream_start && !st_ok;
    rd_ok  = (state == IDLE) && re_en && !stream_start && vec_in(rd_vec) && coef_in(rd_coef);
    rd_bad = re_en && !rd_ok;
    step   = (state == STREAM) && (s_idx != '0);
  end

  // One shared read port: burst start, burst continuation, or random read.
  always_comb begin
    a_vec  = rd_vec;
    a_coef = rd_coef;
    gate   = 1'b0;
    if (st_ok) begin
      a_vec  = stream_vec;
      a_coef = st_deg;
      gate   = 1'b1;
    end else if (step) begin
      a_vec  = s_vec;
      a_coef = s_idx - CA'(1);
      gate   = 1'b1;
    end else if (rd_ok) begin
      gate = valid[rd_vec] && (rd_coef <= deg[rd_vec]);
    end
    rd_word = gate ? mem[a_vec][a_coef] : '0;
`ifdef S_COEF_BANK_RAW_BYPASS_EN
    if ((st_ok || step || rd_ok) && wr_ok && wr_vec == a_vec && wr_coef == a_coef) begin
      rd_word = wr_data;
    end
`endif
  end

  always_comb begin
    deg_out = '0;
    if (vec_in(rd_vec)) deg_out = deg[rd_vec];
  end

  assign state_dbg = (state == STREAM);

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_vec][wr_coef] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s_vec       <= '0;
      s_idx       <= '0;
      q           <= '0;
      q_en        <= 1'b0;
      stream_busy <= 1'b0;
      stream_last <= 1'b0;
      wr_suc      <= 1'b0;
      err         <= 1'b0;
      valid       <= '0;
      for (int i = 0; i < NUM_VECTORS; i++) deg[i] <= '0;
    end else begin
      wr_suc      <= wr_ok;
      err         <= wr_bad || rd_bad || st_bad;
      q_en        <= 1'b0;
      stream_busy <= 1'b0;
      stream_last <= 1'b0;

      if (clr_ok) begin
        valid[clr_vec] <= 1'b0;
        deg[clr_vec]   <= '0;
      end
      if (wr_ok) begin
        valid[wr_vec] <= 1'b1;
        deg[wr_vec]   <= new_deg;
      end

      case (state)
        IDLE: begin
          if (st_ok) begin
            // Burst length is fixed here; later edits to the vector do not alter it.
            state       <= STREAM;
            s_vec       <= stream_vec;
            s_idx       <= st_deg;
            q           <= rd_word;
            q_en        <= 1'b1;
            stream_busy <= 1'b1;
            stream_last <= (st_deg == '0);
          end else if (rd_ok) begin
            q    <= rd_word;
            q_en <= 1'b1;
          end
        end
        STREAM: begin
          if (s_idx == '0) begin
            state <= IDLE;
          end else begin
            s_idx       <= s_idx - CA'(1);
            q           <= rd_word;
            q_en        <= 1'b1;
            stream_busy <= 1'b1;
            stream_last <= (s_idx == CA'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s_coef_bank.sv
// Bench for s_coef_bank: reference model plus expected-output queue for q/q_en/stream flags.
module tb_s_coef_bank;
  localparam int W  = 16;
  localparam int NV = 6;
  localparam int MD = 10;
  localparam int VA = 3;
  localparam int CA = 4;
  localparam int EW = W + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [VA-1:0] wr_vec = '0;
  logic [CA-1:0] wr_coef = '0;
  logic [W-1:0]  wr_data = '0;
  logic          clr_en = 1'b0;
  logic [VA-1:0] clr_vec = '0;
  logic          re_en = 1'b0;
  logic [VA-1:0] rd_vec = '0;
  logic [CA-1:0] rd_coef = '0;
  logic          stream_start = 1'b0;
  logic [VA-1:0] stream_vec = '0;
  logic [W-1:0]  q;
  logic          q_en;
  logic          stream_busy;
  logic          stream_last;
  logic          wr_suc;
  logic          err;
  logic [CA-1:0] deg_out;
  logic          state_dbg;

  s_coef_bank #(.WORD_SIZE(W), .NUM_VECTORS(NV), .MAX_DEGREE(MD)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_vec(wr_vec), .wr_coef(wr_coef), .wr_data(wr_data),
    .clr_en(clr_en), .clr_vec(clr_vec),
    .re_en(re_en), .rd_vec(rd_vec), .rd_coef(rd_coef),
    .stream_start(stream_start), .stream_vec(stream_vec),
    .q(q), .q_en(q_en), .stream_busy(stream_busy), .stream_last(stream_last),
    .wr_suc(wr_suc), .err(err), .deg_out(deg_out), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic          mon_on = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  mem_m [NV][MD+1];
  logic [NV-1:0] valid_m = '0;
  int            deg_m [NV];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every q_en word must match the head of exp_q ({busy,last,q}).
  always @(negedge clk) begin
    if (mon_on) begin
      if (q_en) begin
        if (exp_q.size() == 0) begin
          check("q_en_unexpected", {31'd0, q_en}, 32'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("q_word", 32'({stream_busy, stream_last, q}), 32'(e));
        end
      end else begin
        check("strobes_idle", 32'({stream_busy, stream_last}), 32'd0);
      end
    end
  end

  // Reference model
  function automatic logic [W-1:0] model_rd(input int v, input int c);
    if (valid_m[v] && c <= deg_m[v]) return mem_m[v][c];
    return '0;
  endfunction

  task automatic model_wr(input int v, input int c, input logic [W-1:0] d);
    if (!valid_m[v]) deg_m[v] = c;
    else if (c > deg_m[v]) deg_m[v] = c;
    valid_m[v]  = 1'b1;
    mem_m[v][c] = d;
  endtask

  task automatic model_clr(input int v);
    valid_m[v] = 1'b0;
    deg_m[v]   = 0;
  endtask

  task automatic push_stream(input int v);
    for (int i = deg_m[v]; i >= 0; i--) exp_q.push_back({1'b1, (i == 0), mem_m[v][i]});
  endtask

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int v, input int c, input logic [W-1:0] d);
    bit ok;
    ok      = (v < NV) && (c <= MD);
    wr_en   = 1'b1;
    wr_vec  = v[VA-1:0];
    wr_coef = c[CA-1:0];
    wr_data = d;
    cyc();
    wr_en = 1'b0;
    check("wr_suc", {31'd0, wr_suc}, {31'd0, ok});
    check("wr_err", {31'd0, err}, {31'd0, !ok});
    if (ok) model_wr(v, c, d);
  endtask

  task automatic do_read(input int v, input int c);
    exp_q.push_back({2'b00, model_rd(v, c)});
    re_en   = 1'b1;
    rd_vec  = v[VA-1:0];
    rd_coef = c[CA-1:0];
    cyc();
    re_en = 1'b0;
    check("rd_err", {31'd0, err}, 32'd0);
  endtask

  task automatic do_stream(input int v);
    push_stream(v);
    stream_start = 1'b1;
    stream_vec   = v[VA-1:0];
    cyc();
    stream_start = 1'b0;
    check("st_err", {31'd0, err}, 32'd0);
    check("st_state", {31'd0, state_dbg}, 32'd1);
  endtask

  task automatic do_bad_stream(input int v);
    stream_start = 1'b1;
    stream_vec   = v[VA-1:0];
    cyc();
    stream_start = 1'b0;
    check("bad_st_err", {31'd0, err}, 32'd1);
    check("bad_st_state", {31'd0, state_dbg}, 32'd0);
  endtask

  task automatic check_deg(input int v, input int d);
    rd_vec = v[VA-1:0];
    #1;
    check("deg_out", 32'(deg_out), d);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      cyc();
      n++;
    end
    check("drain", exp_q.size(), 0);
    cyc();
    check("back_idle", {31'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NV; i++) deg_m[i] = 0;

    rst = 1'b1;
    cyc();
    cyc();
    check("rst_q", 32'(q), 0);
    check("rst_flags", 32'({q_en, wr_suc, err, stream_busy, stream_last, state_dbg}), 0);
    check_deg(2, 0);
    rst    = 1'b0;
    mon_on = 1'b1;

    // Fill vector 2 and read it back at random
    do_write(2, 0, 16'h0011);
    do_write(2, 1, 16'h0022);
    do_write(2, 2, 16'h0033);
    do_write(2, 3, 16'h0044);
    check_deg(2, 3);
    for (int c = 0; c < 4; c++) do_read(2, c);
    do_read(2, 5);
    do_read(1, 0);
    do_read(2, $urandom_range(0, 3));

    // Burst of vector 2; requests during the burst are refused, writes accepted
    do_stream(2);
    re_en  = 1'b1;
    rd_vec = 3'd2;
    cyc();
    re_en = 1'b0;
    check("rd_in_stream_err", {31'd0, err}, 32'd1);
    stream_start = 1'b1;
    stream_vec   = 3'd2;
    cyc();
    stream_start = 1'b0;
    check("st_in_stream_err", {31'd0, err}, 32'd1);
    do_write(3, 0, 16'h00A0);
    wait_drain();

    // Clearing mid-burst keeps the latched length
    do_write(3, 1, 16'h00A1);
    do_write(3, 2, 16'h00A2);
    do_stream(3);
    clr_en  = 1'b1;
    clr_vec = 3'd3;
    cyc();
    clr_en = 1'b0;
    model_clr(3);
    wait_drain();
    check_deg(3, 0);
    do_bad_stream(3);

    // Rejected requests
    do_write(NV, 0, 16'hDEAD);
    do_write(2, MD + 1, 16'hBEEF);
    check_deg(2, 3);
    do_bad_stream(5);
    do_bad_stream(7);

    // Read and stream together in idle: stream wins, err flags the dropped read
    push_stream(2);
    stream_start = 1'b1;
    stream_vec   = 3'd2;
    re_en        = 1'b1;
    rd_vec       = 3'd2;
    rd_coef      = 4'd0;
    cyc();
    stream_start = 1'b0;
    re_en        = 1'b0;
    check("both_err", {31'd0, err}, 32'd1);
    wait_drain();

    // Read-after-write in the same cycle
`ifdef S_COEF_BANK_RAW_BYPASS_EN
    exp_q.push_back({2'b00, 16'h00AB});
`else
    exp_q.push_back({2'b00, 16'h0022});
`endif
    re_en   = 1'b1;
    rd_vec  = 3'd2;
    rd_coef = 4'd1;
    wr_en   = 1'b1;
    wr_vec  = 3'd2;
    wr_coef = 4'd1;
    wr_data = 16'h00AB;
    cyc();
    re_en = 1'b0;
    wr_en = 1'b0;
    check("raw_wr_suc", {31'd0, wr_suc}, 32'd1);
    model_wr(2, 1, 16'h00AB);
    do_read(2, 1);

    // Clear, then read returns zero with a valid strobe
    clr_en  = 1'b1;
    clr_vec = 3'd2;
    cyc();
    clr_en = 1'b0;
    model_clr(2);
    check_deg(2, 0);
    do_read(2, 0);

    // Clear and write to the same vector: write wins; degree tracks the max
    clr_en  = 1'b1;
    clr_vec = 3'd4;
    wr_en   = 1'b1;
    wr_vec  = 3'd4;
    wr_coef = 4'd2;
    wr_data = 16'h0042;
    cyc();
    clr_en = 1'b0;
    wr_en  = 1'b0;
    check("clr_wr_suc", {31'd0, wr_suc}, 32'd1);
    model_clr(4);
    model_wr(4, 2, 16'h0042);
    check_deg(4, 2);
    do_write(4, 1, 16'($urandom_range(0, 16'hFFFF)));
    check_deg(4, 2);
    do_write(4, MD, 16'h0A0A);
    check_deg(4, MD);
    do_read(4, MD);

    // Degree-0 burst is a single word flagged last
    do_write(0, 0, 16'h0077);
    do_stream(0);
    wait_drain();

    // Reset in the middle of a burst
    do_write(1, 0, 16'h0010);
    do_write(1, 1, 16'h0011);
    do_write(1, 2, 16'h0012);
    exp_q.push_back({1'b1, 1'b0, 16'h0012});
    stream_start = 1'b1;
    stream_vec   = 3'd1;
    cyc();
    stream_start = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    valid_m = '0;
    for (int i = 0; i < NV; i++) deg_m[i] = 0;
    check("mid_rst_q", 32'(q), 0);
    check("mid_rst_flags", 32'({q_en, wr_suc, err, stream_busy, stream_last, state_dbg}), 0);
    repeat (4) cyc();
    check_deg(1, 0);
    do_read(1, 0);
    do_bad_stream(1);

    repeat (3) cyc();
    check("final_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s_coef_bank.md
S_COEF_BANK -- requirements
Module: s_coef_bank

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: coefficient bit width.
REQ-002 SHALL have parameter NUM_VECTORS, default 8: number of coefficient vectors.
REQ-003 SHALL have parameter MAX_DEGREE, default 10: highest coefficient index per vector.
REQ-004 SHALL derive VA = max(1, clog2(NUM_VECTORS)) and CA = clog2(MAX_DEGREE+1) as address widths.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 wr_en, wr_vec, wr_coef, wr_data  in  1/VA/CA/WORD_SIZE  write request and address.
REQ-009 clr_en, clr_vec  in  1/VA  invalidate one vector.
REQ-010 re_en, rd_vec, rd_coef  in  1/VA/CA  single random read.
REQ-011 stream_start, stream_vec  in  1/VA  start a Horner-order burst read of one vector.
REQ-012 q  out  WORD_SIZE  read data; q_en  out  1  q valid strobe.
REQ-013 stream_busy, stream_last  out  1/1  burst in progress; final burst word.
REQ-014 wr_suc  out  1  write accepted; err  out  1  rejected request.
REQ-015 deg_out  out  CA  degree of vector rd_vec, combinational from registers.

Function
REQ-016 Storage SHALL be NUM_VECTORS x (MAX_DEGREE+1) words plus per-vector valid bit and CA-bit degree register.
REQ-017 In-range write (wr_vec<NUM_VECTORS, wr_coef<=MAX_DEGREE) SHALL store data, set valid, set degree to wr_coef if vector was invalid else max(degree, wr_coef), and pulse wr_suc one cycle later.
REQ-018 Out-of-range write, read, or stream_start SHALL have no storage effect and pulse err one cycle later.
REQ-019 clr_en SHALL clear valid and degree of clr_vec; same-cycle write to same vector SHALL win (valid=1, degree=wr_coef).
REQ-020 FSM states IDLE, STREAM; IDLE->STREAM on stream_start with valid in-range vector; STREAM->IDLE after word with index 0 issued.
REQ-021 Random read in IDLE SHALL present q and pulse q_en exactly one cycle after re_en; coef above degree or invalid vector SHALL return 0.
REQ-022 Stream SHALL emit degree+1 words, indices degree down to 0, one per cycle, first word one cycle after stream_start, q_en high each word, stream_last with index-0 word.
REQ-023 stream_busy SHALL be high from cycle after accepted stream_start until cycle of stream_last inclusive.
REQ-024 Degree latched at stream start SHALL govern burst length; later writes/clears of that vector SHALL not change it.
REQ-025 re_en and stream_start during STREAM SHALL be ignored and pulse err; re_en and stream_start together in IDLE: stream wins, err pulses.
REQ-026 stream_start on invalid vector SHALL pulse err, remain IDLE.
REQ-027 Writes and clears SHALL be accepted in both states.

Reset
REQ-028 rst SHALL force q=0, q_en=0, wr_suc=0, err=0, stream_busy=0, stream_last=0, all valid=0, all degree=0, state IDLE; storage array not cleared.
REQ-029 rst during STREAM SHALL abort burst with no further q_en.

Configuration
REQ-030 Macro S_COEF_BANK_RAW_BYPASS_EN defined: read (random or stream) of address written same cycle SHALL return new wr_data.
REQ-031 Macro undefined: such read SHALL return previously stored word.

Verification
REQ-032 Write v2 coef 0..3 = 0x11,0x22,0x33,0x44 -> wr_suc each next cycle; deg_out(rd_vec=2)=3.
REQ-033 stream_start v2 -> q 0x44,0x33,0x22,0x11 on 4 consecutive cycles, stream_last with 0x11, stream_busy 4 cycles.
REQ-034 Write wr_vec=NUM_VECTORS or wr_coef=MAX_DEGREE+1 -> err pulse, no wr_suc, deg unchanged; stream_start v5 unwritten -> err, no q_en.
REQ-035 re_en v2 coef 1 while wr v2 coef 1 = 0xAB same cycle -> q=0xAB with macro, 0x22 without.
REQ-036 clr_en v2 then re_en v2 coef 0 -> q=0, q_en=1; rst mid-stream -> outputs 0, valid cleared.
